uart_transmitter: RTL
=====================

Name: uart_transmitter

Overview:
- Serial transmit end of the CPU's UART byte interface.
- The datapath presents a store byte on DataIn and pulses DataInValid. This block accepts the byte on a valid/ready handshake and shifts it out as an 8N1 asynchronous frame on SerialOut.
- DataInReady is what the CPU polls through its UART status read.
- Sits between the datapath's UART store path and the board TX pin.

Parameters:
- CLOCK_FREQ, 50_000_000, CLK frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits per second.
- SYMBOL_EDGE_TIME: derived localparam, CLOCK_FREQ / BAUD_RATE with integer truncation; 434 at the defaults. This is the cycles-per-symbol value T.
- CLOCK_COUNTER_WIDTH: derived localparam, $clog2(SYMBOL_EDGE_TIME).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- DataIn  input  8  byte to transmit; sampled only on the accept edge.
- DataInValid  input  1  CPU has a byte to send.
- DataInReady  output  1  transmitter idle and able to accept.
- SerialOut  output  1  UART TX line; idle high.

Behaviour:
- Interface decision: one clock, CLK. reset is synchronous and active-high.
- Reset state, effective on the edge where reset=1:
  - state=IDLE, SerialOut=1, DataInReady=1, all counters 0, shift register 0.
  - Reset wins over every other event.
  - Reset mid-frame abandons the frame; SerialOut is 1 from the next edge.
- States: IDLE, START, DATA, STOP. With the option enabled, PARITY sits between DATA and STOP.
- DataInReady is registered and equals (state==IDLE).
- Accept: on a rising edge with DataInValid=1 and DataInReady=1:
  - DataIn is latched into a 10-bit shift register {1'b1, DataIn, 1'b0}.
  - state moves to START.
  - The clock counter clears.
- DataInValid while DataInReady=0 is ignored. No queuing; the CPU must poll ready.
- DataIn changes after accept have no effect on the frame in flight.
- Symbol timing: SerialOut is driven from the shift register LSB, one bit per symbol, each bit held exactly T cycles.
  - The clock counter runs 0..T-1 and wraps to 0 at T-1.
  - A symbol advance occurs on the wrap edge.
- Sequence, for accept edge at cycle k:
  - Start bit (0) on cycles k+1 .. k+T.
  - Data bits D0 (LSB first) through D7 follow, T cycles each.
  - Stop bit (1) on cycles k+1+9T .. k+10T.
  - state=IDLE and DataInReady=1 from cycle k+1+10T.
- Bit counter: 0..7 in DATA; DATA exits to STOP when bit 7's symbol wraps.
- Back-to-back: if DataInValid is held high, the next accept occurs on the first IDLE cycle. The minimum frame-to-frame period is 10T+1 cycles; SerialOut stays 1 during that idle cycle.
- SerialOut is registered, glitch-free, and never X after reset.
- Counter widths never overflow: the clock counter compares against SYMBOL_EDGE_TIME-1 at CLOCK_COUNTER_WIDTH bits.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - An even parity bit, the XOR of DataIn[7:0], is computed at the accept edge.
  - It is transmitted for T cycles in state PARITY, between D7 and the stop bit.
  - Frame is 11 symbols; DataInReady returns 11T+1 cycles after accept.
- When undefined:
  - PARITY state and parity logic are absent.
  - Frame is 8N1 as above, 10 symbols.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100, so T=10, unless noted):
- Reset then idle, no valid for 50 cycles -> SerialOut=1 and DataInReady=1 on every cycle after reset deasserts.
- Accept 0x55 at cycle k:
  - DataInReady=0 from k+1.
  - SerialOut 10-cycle symbols 0,1,0,1,0,1,0,1,0 then 1, from k+1 through k+100.
  - DataInReady=1 at k+101.
- Accept 0xA3 with DataIn toggled to 0xFF and DataInValid pulsed mid-frame:
  - Line carries start, 1,1,0,0,0,1,0,1, stop.
  - The second pulse is not accepted; only one frame is sent.
- Valid held high with 0x01 then 0x80 presented on consecutive accepts:
  - Two frames separated by exactly one idle-high cycle.
  - Second accept at k+101.
- Assert reset during D3 of a frame -> SerialOut=1 and DataInReady=1 from the edge after reset; the subsequent 0x0F frame is bit-exact.
- With UART_TX_PARITY_EN, send 0x07 -> parity symbol = 1 on cycles k+91..k+100, stop on k+101..k+110, DataInReady=1 at k+111.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// Byte handshake between the CPU UART store path and the transmitter.
// The CPU side (master) presents a byte with DataInValid; the transmitter
// side (slave) answers with DataInReady while it is idle.
interface uart_transmitter_if;
    logic [7:0] DataIn;
    logic       DataInValid;
    logic       DataInReady;

    modport master (
        output DataIn,
        output DataInValid,
        input  DataInReady
    );

    modport slave (
        input  DataIn,
        input  DataInValid,
        output DataInReady
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts a byte on a valid/ready handshake and shifts it
// out LSB first as an asynchronous frame (start, 8 data, stop), each symbol
// held SYMBOL_EDGE_TIME clock cycles.
// Optional even parity bit between D7 and stop: define UART_TX_PARITY_EN.
module uart_transmitter #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic              CLK,
    input  logic              reset,
    uart_transmitter_if.slave bus,
    output logic              SerialOut
);

    localparam int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] COUNT_ONE = CLOCK_COUNTER_WIDTH'(1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e                         state_q, state_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]                     bit_cnt_q, bit_cnt_d;
    logic [9:0]                     shift_q, shift_d;
    logic                           serial_q, serial_d;
    logic                           ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic                           parity_q, parity_d;
`endif

    logic accept;
    logic symbol_done;

    assign accept      = bus.DataInValid & ready_q;
    assign symbol_done = (clk_cnt_q == LAST_COUNT);

    // State and datapath registers; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next-state logic: every non-idle state advances on a symbol wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StStart;
            StStart:  if (symbol_done) state_d = StData;
            StData: begin
                if (symbol_done && bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: if (symbol_done) state_d = StStop;
`endif
            StStop:   if (symbol_done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Counters, shift register and the registered line/ready values.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q == StIdle) begin
            clk_cnt_d = '0;
            serial_d  = 1'b1;
            if (accept) begin
                shift_d  = {1'b1, bus.DataIn, 1'b0};
                serial_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_d = ^bus.DataIn;
`endif
            end
        end else begin
            clk_cnt_d = symbol_done ? '0 : clk_cnt_q + COUNT_ONE;
            if (symbol_done) begin
                // Shift in ones so the stop bit reaches bit 1 after D7.
                shift_d  = (shift_q >> 1) | 10'h200;
                serial_d = shift_q[1];
                if (state_q == StData) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_cnt_q == 3'd7) serial_d = parity_q;
`endif
                end
                if (state_q == StStop) serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                if (state_q == StParity) serial_d = 1'b1;
`endif
            end
        end

        ready_d = (state_d == StIdle);
    end

    assign SerialOut       = serial_q;
    assign bus.DataInReady = ready_q;

endmodule
